// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with a memory
// wait-timeout, sticky fault code and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic [3:0]       alu_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    localparam logic [5:0] OpRtype  = 6'b000000;
    localparam logic [5:0] OpImm    = 6'b000001;
    localparam logic [5:0] OpLoad   = 6'b000010;
    localparam logic [5:0] OpStore  = 6'b000011;
    localparam logic [5:0] OpBranch = 6'b000100;
    localparam logic [5:0] OpJump   = 6'b000101;
    localparam logic [5:0] OpHalt   = 6'b111111;

    localparam logic [1:0] FaultNone    = 2'b00;
    localparam logic [1:0] FaultIllegal = 2'b01;
    localparam logic [1:0] FaultBus     = 2'b10;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StFault  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         fault_q, fault_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [WaitW-1:0]   wait_inc;
    logic               wait_expired;
    logic               unused_funct;

    assign unused_funct = ^funct[5:4];
    assign wait_inc     = wait_q + WaitW'(1);
    assign wait_expired = (wait_inc == WaitW'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        wait_d    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_sel    = 2'b00;
        reg_write = 1'b0;
        alu_op    = 4'b0000;

        if (state_q inside {StDecode, StExec, StMem, StWb}) begin
            alu_op = (opcode == OpRtype) ? funct[3:0] : 4'b0000;
        end

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_sel   = 2'b01;
                    state_d  = StDecode;
                end else if (wait_expired) begin
                    state_d = StFault;
                    fault_d = FaultBus;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StDecode: begin
                if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else if (opcode inside {OpRtype, OpImm, OpLoad, OpStore, OpBranch, OpJump}) begin
                    state_d = StExec;
                end else begin
                    state_d = StFault;
                    fault_d = FaultIllegal;
                end
            end
            StExec: begin
                case (opcode)
                    OpRtype, OpImm:  state_d = StWb;
                    OpLoad, OpStore: state_d = StMem;
                    OpBranch: begin
                        pc_sel    = zero ? 2'b10 : 2'b00;
                        state_d   = StFetch;
                        retired_d = retired_q + CNT_W'(1);
                    end
                    OpJump: begin
                        pc_sel    = 2'b11;
                        state_d   = StFetch;
                        retired_d = retired_q + CNT_W'(1);
                    end
                    // Opcode changed under us after decode: treat as illegal.
                    default: begin
                        state_d = StFault;
                        fault_d = FaultIllegal;
                    end
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OpStore);
                if (mem_ready) begin
                    if (opcode == OpStore) begin
                        state_d   = StFetch;
                        retired_d = retired_q + CNT_W'(1);
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_expired) begin
                    state_d = StFault;
                    fault_d = FaultBus;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
                retired_d = retired_q + CNT_W'(1);
            end
            StHalt, StFault: state_d = state_q;
            default:         state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            fault_q   <= FaultNone;
            retired_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == StHalt);
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by random instruction
// streams, checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, ir_write, reg_write, halted;
    logic [1:0]    pc_sel, fault;
    logic [3:0]    alu_op;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_ret = '0;
    int            exp_flt = 0;
    bit            ended;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_write  (ir_write),
        .pc_sel    (pc_sel),
        .reg_write (reg_write),
        .alu_op    (alu_op),
        .state     (state),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input bit mr, input bit mw,
                           input bit ir, input int ps, input bit rw);
        chk({tag, ".state"},     32'(state),     32'(st));
        chk({tag, ".mem_req"},   32'(mem_req),   32'(mr));
        chk({tag, ".mem_we"},    32'(mem_we),    32'(mw));
        chk({tag, ".ir_write"},  32'(ir_write),  32'(ir));
        chk({tag, ".pc_sel"},    32'(pc_sel),    32'(ps));
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
        chk({tag, ".halted"},    32'(halted),    32'(st == 5));
        chk({tag, ".fault"},     32'(fault),     32'(exp_flt));
        chk({tag, ".retired"},   32'(retired),   32'(exp_ret));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
        exp_ret   = '0;
        exp_flt   = 0;
    endtask

    // HALT/FAULT must hold with strobes low regardless of inputs, until reset.
    task automatic terminal(input int st);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            opcode    = 6'($urandom);
            #1;
            chk_all("term", st, 0, 0, 0, 0, 0);
        end
        do_reset();
    endtask

    // One instruction: flat/mlat = cycles of mem_ready low before the response (>= TO: never).
    task automatic do_instr(input logic [5:0] op, input int flat, input int mlat, input bit z,
                            input int rst_at, output bit fin);
        bit is_mem;
        fin = 1'b0;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            mem_ready = (c == flat);
            zero      = 1'($urandom);
            opcode    = 6'($urandom);
            #1;
            chk_all("fetch", 0, 1, 0, c == flat, (c == flat) ? 1 : 0, 0);
            if (c == flat) break;
        end
        if (flat >= TO) begin
            exp_flt = 2;
            terminal(6);
            fin = 1'b1;
            return;
        end
        @(negedge clk);
        opcode    = op;
        funct     = 6'($urandom);
        mem_ready = 1'($urandom);
        zero      = 1'($urandom);
        #1;
        chk_all("decode", 1, 0, 0, 0, 0, 0);
        if (op == 6'd63) begin
            terminal(5);
            fin = 1'b1;
            return;
        end
        if (!(op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5})) begin
            exp_flt = 1;
            terminal(6);
            fin = 1'b1;
            return;
        end
        @(negedge clk);
        mem_ready = 1'($urandom);
        zero      = z;
        #1;
        chk_all("exec", 2, 0, 0, 0, (op == 6'd4) ? (z ? 2 : 0) : ((op == 6'd5) ? 3 : 0), 0);
        chk("exec.alu_op", 32'(alu_op), (op == 6'd0) ? 32'(funct[3:0]) : 32'd0);
        if (op == 6'd4 || op == 6'd5) begin
            exp_ret++;
            return;
        end
        is_mem = (op == 6'd2 || op == 6'd3);
        if (is_mem) begin
            for (int c = 0; c < TO; c++) begin
                @(negedge clk);
                if (c == rst_at) begin
                    rst       = 1'b1;
                    mem_ready = 1'b1;
                    #1;
                    chk_all("mem_rst", 3, 1, op == 6'd3, 0, 0, 0);
                    @(posedge clk);
                    #1;
                    rst       = 1'b0;
                    mem_ready = 1'b0;
                    exp_ret   = '0;
                    exp_flt   = 0;
                    fin       = 1'b1;
                    return;
                end
                mem_ready = (c == mlat);
                #1;
                chk_all("mem", 3, 1, op == 6'd3, 0, 0, 0);
                if (c == mlat) break;
            end
            if (mlat >= TO) begin
                exp_flt = 2;
                terminal(6);
                fin = 1'b1;
                return;
            end
            if (op == 6'd3) begin
                exp_ret++;
                return;
            end
        end
        @(negedge clk);
        mem_ready = 1'($urandom);
        #1;
        chk_all("wb", 4, 0, 0, 0, 0, 1);
        exp_ret++;
    endtask

    initial begin
        int r;
        logic [5:0] op;
        int fl, ml;
        do_reset();
        // Directed scenarios
        do_instr(6'd0, 2, 0, 0, -1, ended);         // R-type, reset state seen in first fetch
        do_instr(6'd0, 0, 0, 0, -1, ended);         // R-type, ready tied high
        do_instr(6'd2, 0, 3, 0, -1, ended);         // load, memory 3 cycles late
        do_instr(6'd4, 0, 0, 1, -1, ended);         // branch taken
        do_instr(6'd4, 0, 0, 0, -1, ended);         // branch not taken
        do_instr(6'd5, 1, 0, 0, -1, ended);         // jump
        do_instr(6'd3, 0, 0, 0, -1, ended);         // store
        do_instr(6'd1, TO - 1, 0, 0, -1, ended);    // ready on the last allowed cycle
        do_instr(6'd0, TO, 0, 0, -1, ended);        // fetch timeout -> bus fault
        do_instr(6'd8, 0, 0, 0, -1, ended);         // illegal opcode
        do_instr(6'd3, 0, 5, 0, 2, ended);          // reset mid-store
        do_instr(6'd0, 1, 0, 0, -1, ended);         // stale ready ignored after reset
        do_instr(6'd2, 0, TO, 0, -1, ended);        // MEM timeout
        do_instr(6'd63, 0, 0, 0, -1, ended);        // halt
        for (int i = 0; i < 2 * (1 << CW) + 2; i++) begin
            do_instr(6'd5, 0, 0, 0, -1, ended);     // retired counter wraps
        end
        // Random instruction stream
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r < 3 || r > 17)  op = 6'd0;
            else if (r < 5)       op = 6'd1;
            else if (r < 8)       op = 6'd2;
            else if (r < 11)      op = 6'd3;
            else if (r < 14)      op = 6'd4;
            else if (r < 16)      op = 6'd5;
            else if (r == 16)     op = 6'd63;
            else                  op = 6'(8 + $urandom_range(0, 50));
            fl = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 4);
            ml = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 4);
            do_instr(op, fl, ml, 1'($urandom), -1, ended);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
